sync_wconv_fifo: RTL
====================

// Module: sync_wconv_fifo
// PURPOSE
//  Single-clock FIFO with power-of-two width conversion in either direction (wide->narrow or narrow->wide).
//  Exports water levels, almost flags and overflow/underflow pulses on both sides.
//  Sits between DDR read bursts and the pixel pipeline, and between pixel packers and DDR write bursts,
//  wherever both sides share one clock.
// PARAMETERS
//  WR_DATA_WIDTH    128  write word width; WR/RD width ratio is 2^k, either direction, 1..64
//  RD_DATA_WIDTH    16   read word width
//  WR_DEPTH_WIDTH   9    log2 of capacity in write words (512); RD_DEPTH_WIDTH derived = WR_DEPTH_WIDTH+log2(WR/RD)
//  ALMOST_FULL_NUM  252  almost_full asserted when wr_water_level >= this value
//  ALMOST_EMPTY_NUM 4    almost_empty asserted when rd_water_level <= this value
// PORTS
//  clk            in  1      single clock, rising edge
//  rst_n          in  1      asynchronous reset, active-low
//  wr_en          in  1      write request
//  wr_data        in  WR_DATA_WIDTH    write word
//  wr_full        out 1      fewer than one write word of free space
//  almost_full    out 1      write-side threshold flag
//  wr_water_level out WR_DEPTH_WIDTH+1 occupancy in whole write words (floor)
//  wr_overflow    out 1      1-cycle pulse: wr_en while wr_full, write dropped
//  rd_en          in  1      read request
//  rd_data        out RD_DATA_WIDTH    read word
//  rd_valid       out 1      rd_data holds a newly read word this cycle
//  rd_empty       out 1      fewer than one read word stored
//  almost_empty   out 1      read-side threshold flag
//  rd_water_level out RD_DEPTH_WIDTH+1 occupancy in whole read words (floor)
//  rd_underflow   out 1      1-cycle pulse: rd_en while rd_empty, read dropped
// BEHAVIOUR
//  - Storage unit U = min(WR,RD) bits. WR_R = WR/U, RD_R = RD/U.
//  - Unit occupancy counter occ, width UNIT_AW+1.
//  - Accepted write adds WR_R units; accepted read removes RD_R units.
//  - Lane order: little-endian. Bits [U-1:0] of a wide word are the first narrow word in or out.
//  - Accept rules: write accepted iff wr_en & !wr_full; read accepted iff rd_en & !rd_empty.
//    Both flags are evaluated on pre-edge (registered) state.
//  - Simultaneous accepted write and read: occ += WR_R-RD_R in one cycle. Pointers wrap modulo the unit capacity.
//  - A write presented while wr_full is dropped even if a read is accepted the same cycle.
//  - All flags and levels are registered and reflect occ after the edge:
//    wr_full = (cap-occ) < WR_R; rd_empty = occ < RD_R; wr_water_level = occ/WR_R; rd_water_level = occ/RD_R.
//  - Latency: write-to-rd_empty deassertion is 1 cycle. Read data: rd_data/rd_valid appear 1 cycle after an accepted rd_en.
//    rd_data holds its value when no read is accepted.
//  - Overflow/underflow: the request is ignored, no state changes, and the matching pulse fires the next cycle.
//  - Reset (any time, including mid-burst): occ=0, pointers=0, rd_empty=1, almost_empty=1, wr_full=0,
//    almost_full=0, levels=0, rd_data=0, rd_valid=0, pulses=0. RAM contents are not cleared.
// CONFIGURATION
//  `SYNC_WCONV_FIFO_OUTREG_EN defined:
//    - adds a data output register; read latency is 2 cycles, and rd_valid is delayed to match;
//    - flags and levels are unchanged.
//  Macro undefined: 1-cycle read latency as above.
// STRUCTURE
//  - Package fifo_pkg:
//    - clog2 function;
//    - width-ratio and unit-address-width localparam helpers;
//    - reset-value constants for flags.
//  - Sub-module sync_fifo_sdpram: simple dual-port RAM, U-bit lanes with per-lane write enables,
//    1-cycle registered read. Parent does lane muxing and packing.
// TESTING (default 128->16 unless stated)
//  1. Write 128'h0007_0006_0005_0004_0003_0002_0001_0000, then 8 back-to-back reads
//     -> rd_data 16'h0000..16'h0007 in order, rd_valid 8 cycles, then rd_empty=1.
//  2. 512 writes -> wr_full=1 the cycle after the 512th.
//     513th write -> wr_overflow pulse; wr_water_level stays 512, rd_water_level 4096.
//  3. Threshold sweep: almost_full rises after the 252nd write.
//     Draining to rd_water_level=4 -> almost_empty=1; 5 -> 0.
//  4. Instance 16->128: 7 writes -> rd_empty stays 1; 8th write -> rd_empty=0 next cycle;
//     read returns {w7,...,w0}.
//  5. Steady simultaneous wr_en/rd_en with 128->128 at level 10 -> level stays 10, no pulses;
//     rd_en at empty -> rd_underflow pulse, no rd_valid.
//  6. rst_n low mid-burst at level 100 -> all outputs take reset values asynchronously;
//     the first post-reset write/read pair returns the new data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the width-converting FIFO: ceil-log2, unit-width and
// ratio arithmetic used to size the storage, and the reset values of the flags.
package fifo_pkg;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Storage unit: the narrower of the two port widths.
    function automatic int unsigned unit_width(input int unsigned wr_w, input int unsigned rd_w);
        return (wr_w < rd_w) ? wr_w : rd_w;
    endfunction

    // Number of storage units per port word.
    function automatic int unsigned width_ratio(input int unsigned word_w, input int unsigned unit_w);
        return word_w / unit_w;
    endfunction

    // Address width of the FIFO when counted in storage units.
    function automatic int unsigned unit_addr_width(input int unsigned wr_depth_w,
                                                    input int unsigned wr_w,
                                                    input int unsigned rd_w);
        return wr_depth_w + clog2(width_ratio(wr_w, unit_width(wr_w, rd_w)));
    endfunction

    // Depth of the FIFO counted in read words (log2).
    function automatic int unsigned rd_depth_width(input int unsigned wr_depth_w,
                                                   input int unsigned wr_w,
                                                   input int unsigned rd_w);
        return unit_addr_width(wr_depth_w, wr_w, rd_w)
               - clog2(width_ratio(rd_w, unit_width(wr_w, rd_w)));
    endfunction

    localparam logic RST_WR_FULL      = 1'b0;
    localparam logic RST_ALMOST_FULL  = 1'b0;
    localparam logic RST_RD_EMPTY     = 1'b1;
    localparam logic RST_ALMOST_EMPTY = 1'b1;

endpackage

// File: rtl/sync_wconv_fifo_if.sv
// Write/read handshake bundle of sync_wconv_fifo.
//   master : producer/consumer side (drives wr_en, wr_data, rd_en)
//   slave  : FIFO side (drives flags, levels, pulses, rd_data, rd_valid)
interface sync_wconv_fifo_if #(
    parameter int unsigned WR_DATA_WIDTH  = 128,
    parameter int unsigned RD_DATA_WIDTH  = 16,
    parameter int unsigned WR_DEPTH_WIDTH = 9,
    parameter int unsigned RD_DEPTH_WIDTH = fifo_pkg::rd_depth_width(WR_DEPTH_WIDTH,
                                                                     WR_DATA_WIDTH,
                                                                     RD_DATA_WIDTH)
);
    logic                      wr_en;
    logic [WR_DATA_WIDTH-1:0]  wr_data;
    logic                      wr_full;
    logic                      almost_full;
    logic [WR_DEPTH_WIDTH:0]   wr_water_level;
    logic                      wr_overflow;

    logic                      rd_en;
    logic [RD_DATA_WIDTH-1:0]  rd_data;
    logic                      rd_valid;
    logic                      rd_empty;
    logic                      almost_empty;
    logic [RD_DEPTH_WIDTH:0]   rd_water_level;
    logic                      rd_underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  wr_full, almost_full, wr_water_level, wr_overflow,
        input  rd_data, rd_valid, rd_empty, almost_empty, rd_water_level, rd_underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output wr_full, almost_full, wr_water_level, wr_overflow,
        output rd_data, rd_valid, rd_empty, almost_empty, rd_water_level, rd_underflow
    );

endinterface

// File: rtl/sync_fifo_sdpram.sv
// Simple dual-port RAM built from LANES independent banks of LANE_WIDTH bits.
// Each bank has its own write enable; the read side returns a whole row through
// a reset-able output register (1-cycle read latency, holds when re is low).
// Ports: clk, rst_n, we/be/waddr/wdata (write), re/raddr/rdata (read).
module sync_fifo_sdpram #(
    parameter int unsigned LANE_WIDTH = 16,
    parameter int unsigned LANES      = 8,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                we,
    input  logic [LANES-1:0]                    be,
    input  logic [ADDR_WIDTH-1:0]               waddr,
    input  logic [LANES-1:0][LANE_WIDTH-1:0]    wdata,
    input  logic                                re,
    input  logic [ADDR_WIDTH-1:0]               raddr,
    output logic [LANES-1:0][LANE_WIDTH-1:0]    rdata
);
    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_WIDTH-1:0] mem [DEPTH];
        logic [LANE_WIDTH-1:0] q;

        // Bank storage; contents are never cleared.
        always_ff @(posedge clk) begin
            if (we && be[g]) begin
                mem[waddr] <= wdata[g];
            end
        end

        // Registered read port.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (re) begin
                q <= mem[raddr];
            end
        end

        assign rdata[g] = q;
    end

endmodule

// File: rtl/sync_wconv_fifo.sv
// Single-clock FIFO with power-of-two width conversion (wide->narrow or
// narrow->wide). Storage is counted in units of min(WR,RD) bits; lanes are
// little-endian (bits [U-1:0] of a wide word are the first narrow word).
// Ports: clk, rst_n (async, active-low), bus (sync_wconv_fifo_if.slave):
//   write side : wr_en, wr_data, wr_full, almost_full, wr_water_level, wr_overflow
//   read side  : rd_en, rd_data, rd_valid, rd_empty, almost_empty, rd_water_level, rd_underflow
// Build option: SYNC_WCONV_FIFO_OUTREG_EN adds a read-data output register
// (2-cycle read latency, rd_valid delayed to match); flags and levels unchanged.
module sync_wconv_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WR_DATA_WIDTH    = 128,
    parameter int unsigned RD_DATA_WIDTH    = 16,
    parameter int unsigned WR_DEPTH_WIDTH   = 9,
    parameter int unsigned ALMOST_FULL_NUM  = 252,
    parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sync_wconv_fifo_if.slave bus
);
    localparam int unsigned U              = unit_width(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int unsigned WR_R           = width_ratio(WR_DATA_WIDTH, U);
    localparam int unsigned RD_R           = width_ratio(RD_DATA_WIDTH, U);
    localparam int unsigned WR_R_LOG       = clog2(WR_R);
    localparam int unsigned RD_R_LOG       = clog2(RD_R);
    localparam int unsigned UNIT_AW        = unit_addr_width(WR_DEPTH_WIDTH, WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int unsigned RD_DEPTH_WIDTH = rd_depth_width(WR_DEPTH_WIDTH, WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int unsigned OCC_W          = UNIT_AW + 1;
    localparam int unsigned WL_W           = WR_DEPTH_WIDTH + 1;
    localparam int unsigned RL_W           = RD_DEPTH_WIDTH + 1;
    localparam int unsigned CAP            = 32'd1 << UNIT_AW;
    localparam int unsigned LANES          = (WR_R > RD_R) ? WR_R : RD_R;
    localparam int unsigned LANE_LOG       = clog2(LANES);
    localparam int unsigned ROW_AW         = UNIT_AW - LANE_LOG;

    // Pointer / occupancy state, all in storage units.
    logic [UNIT_AW-1:0] wr_ptr;
    logic [UNIT_AW-1:0] rd_ptr;
    logic [OCC_W-1:0]   occ;

    // Registered flags, levels and pulses.
    logic               wr_full_q;
    logic               almost_full_q;
    logic [WL_W-1:0]    wr_level_q;
    logic               wr_overflow_q;
    logic               rd_empty_q;
    logic               almost_empty_q;
    logic [RL_W-1:0]    rd_level_q;
    logic               rd_underflow_q;
    logic               rd_valid_q;

    // Next-state terms.
    logic               wr_acc;
    logic               rd_acc;
    logic [OCC_W-1:0]   occ_nxt;
    logic [OCC_W-1:0]   free_nxt;
    logic [WL_W-1:0]    wr_level_nxt;
    logic [RL_W-1:0]    rd_level_nxt;

    // RAM hookup.
    logic [LANES-1:0]         ram_be;
    logic [LANES-1:0][U-1:0]  ram_wdata;
    logic [ROW_AW-1:0]        ram_waddr;
    logic [ROW_AW-1:0]        ram_raddr;
    logic [LANES-1:0][U-1:0]  ram_q;
    logic [RD_DATA_WIDTH-1:0] rd_word;

    // Accept decisions use pre-edge flags; a dropped write stays dropped even
    // if a read frees space in the same cycle.
    always_comb begin
        wr_acc       = bus.wr_en & ~wr_full_q;
        rd_acc       = bus.rd_en & ~rd_empty_q;
        occ_nxt      = occ;
        if (wr_acc) begin
            occ_nxt = occ_nxt + OCC_W'(WR_R);
        end
        if (rd_acc) begin
            occ_nxt = occ_nxt - OCC_W'(RD_R);
        end
        free_nxt     = OCC_W'(CAP) - occ_nxt;
        wr_level_nxt = WL_W'(occ_nxt >> WR_R_LOG);
        rd_level_nxt = RL_W'(occ_nxt >> RD_R_LOG);
    end

    // State, flag and level registers; flags reflect occupancy after the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occ            <= '0;
            wr_full_q      <= RST_WR_FULL;
            almost_full_q  <= RST_ALMOST_FULL;
            wr_level_q     <= '0;
            wr_overflow_q  <= 1'b0;
            rd_empty_q     <= RST_RD_EMPTY;
            almost_empty_q <= RST_ALMOST_EMPTY;
            rd_level_q     <= '0;
            rd_underflow_q <= 1'b0;
            rd_valid_q     <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + UNIT_AW'(WR_R);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + UNIT_AW'(RD_R);
            end
            occ            <= occ_nxt;
            wr_full_q      <= (free_nxt < OCC_W'(WR_R));
            almost_full_q  <= (wr_level_nxt >= WL_W'(ALMOST_FULL_NUM));
            wr_level_q     <= wr_level_nxt;
            wr_overflow_q  <= bus.wr_en & wr_full_q;
            rd_empty_q     <= (occ_nxt < OCC_W'(RD_R));
            almost_empty_q <= (rd_level_nxt <= RL_W'(ALMOST_EMPTY_NUM));
            rd_level_q     <= rd_level_nxt;
            rd_underflow_q <= bus.rd_en & rd_empty_q;
            rd_valid_q     <= rd_acc;
        end
    end

    // A RAM row is one wide word; the unit pointer splits into row and lane.
    assign ram_waddr = wr_ptr[UNIT_AW-1:LANE_LOG];
    assign ram_raddr = rd_ptr[UNIT_AW-1:LANE_LOG];

    // Write packing: a wide write fills a row, a narrow write targets one lane.
    if (WR_R == LANES) begin : g_wr_wide
        assign ram_be    = '1;
        assign ram_wdata = bus.wr_data;
    end else begin : g_wr_narrow
        assign ram_be    = LANES'(1) << wr_ptr[LANE_LOG-1:0];
        assign ram_wdata = {LANES{bus.wr_data}};
    end

    sync_fifo_sdpram #(
        .LANE_WIDTH (U),
        .LANES      (LANES),
        .ADDR_WIDTH (ROW_AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .be    (ram_be),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_acc),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    // Read unpacking: a narrow read picks the lane captured with the request,
    // so the selection stays stable while the RAM output holds.
    if (RD_R == LANES) begin : g_rd_wide
        assign rd_word = ram_q;
    end else begin : g_rd_narrow
        logic [LANE_LOG-1:0] lane_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane_q <= '0;
            end else if (rd_acc) begin
                lane_q <= rd_ptr[LANE_LOG-1:0];
            end
        end

        assign rd_word = ram_q[lane_q];
    end

`ifdef SYNC_WCONV_FIFO_OUTREG_EN
    logic [RD_DATA_WIDTH-1:0] rd_data_q;
    logic                     rd_valid_q2;

    // Extra output stage; captures only freshly read words so rd_data holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q   <= '0;
            rd_valid_q2 <= 1'b0;
        end else begin
            rd_valid_q2 <= rd_valid_q;
            if (rd_valid_q) begin
                rd_data_q <= rd_word;
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q2;
`else
    assign bus.rd_data  = rd_word;
    assign bus.rd_valid = rd_valid_q;
`endif

    assign bus.wr_full        = wr_full_q;
    assign bus.almost_full    = almost_full_q;
    assign bus.wr_water_level = wr_level_q;
    assign bus.wr_overflow    = wr_overflow_q;
    assign bus.rd_empty       = rd_empty_q;
    assign bus.almost_empty   = almost_empty_q;
    assign bus.rd_water_level = rd_level_q;
    assign bus.rd_underflow   = rd_underflow_q;

endmodule
